// File: rtl/jzjpcc_isa_pkg.sv
// Shared RV32I ISA definitions: opcodes, instruction formats, immediate ranges.
// Used by both the decode stage and the instruction encoder.
package jzjpcc_isa_pkg;

    typedef enum logic [4:0] {
        OPC_LOAD     = 5'b00000,
        OPC_MISC_MEM = 5'b00011,
        OPC_OP_IMM   = 5'b00100,
        OPC_AUIPC    = 5'b00101,
        OPC_STORE    = 5'b01000,
        OPC_OP       = 5'b01100,
        OPC_LUI      = 5'b01101,
        OPC_BRANCH   = 5'b11000,
        OPC_JALR     = 5'b11001,
        OPC_JAL      = 5'b11011,
        OPC_SYSTEM   = 5'b11100
    } opcode_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    localparam logic signed [31:0] IMM_I_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM_I_MAX = 32'sd2047;
    localparam logic signed [31:0] IMM_B_MIN = -32'sd4096;
    localparam logic signed [31:0] IMM_B_MAX = 32'sd4094;
    localparam logic signed [31:0] IMM_J_MIN = -32'sd1048576;
    localparam logic signed [31:0] IMM_J_MAX = 32'sd1048574;

    // S1 holding register: request fields plus their classification
    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        fmt_e        fmt;
        logic        err;
    } s1_t;

    function automatic fmt_e opcode_format(input logic [4:0] op);
        fmt_e f;
        case (op)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM: f = FMT_I;
            OPC_STORE:                f = FMT_S;
            OPC_BRANCH:               f = FMT_B;
            OPC_LUI, OPC_AUIPC:       f = FMT_U;
            OPC_JAL:                  f = FMT_J;
            OPC_OP:                   f = FMT_R;
            default:                  f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/jzjpcc_imm_range_check.sv
// Combinational format classifier and immediate representability check.
import jzjpcc_isa_pkg::*;

module jzjpcc_imm_range_check (
    input  logic [4:0]  opcode_i,
    input  logic [31:0] imm_i,
    output fmt_e        fmt_o,
    output logic        err_o
);

    logic signed [31:0] simm;
    logic               in_i;
    logic               in_b;
    logic               in_j;

    always_comb begin
        simm = $signed(imm_i);
        in_i = (simm >= IMM_I_MIN) && (simm <= IMM_I_MAX);
        in_b = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX);
        in_j = (simm >= IMM_J_MIN) && (simm <= IMM_J_MAX);
        fmt_o = opcode_format(opcode_i);
        unique case (fmt_o)
            FMT_R:        err_o = 1'b0;
            FMT_I, FMT_S: err_o = !in_i;
            FMT_B:        err_o = !in_b || imm_i[0];
            FMT_J:        err_o = !in_j || imm_i[0];
            FMT_U:        err_o = |imm_i[11:0];
            default:      err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/jzjpcc_instruction_encoder.sv
// Two-stage RV32I instruction encoder: S1 classifies, S2 holds the packed
// word; valid/ready on both ends with a saturating error counter.
import jzjpcc_isa_pkg::*;

module jzjpcc_instruction_encoder #(
    parameter int ERROR_COUNT_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4:0]                   opcode,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    input  logic [2:0]                   funct3,
    input  logic [6:0]                   funct7,
    input  logic [31:0]                  immediate,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  instruction,
    output logic                         imm_error,
    output logic [ERROR_COUNT_WIDTH-1:0] error_count
);

    logic                         s1_valid_q, s1_valid_d;
    s1_t                          s1_q, s1_d;
    logic                         s2_valid_q, s2_valid_d;
    logic [31:0]                  word_q, word_d;
    logic                         err_q, err_d;
    logic [ERROR_COUNT_WIDTH-1:0] cnt_q, cnt_d;

    fmt_e        fmt_c;
    logic        rerr_c;
    logic [31:0] pack_c;
    logic [6:0]  op7;
    logic [31:0] imm;
    logic        s2_load;
    logic        s1_adv;
    logic        in_fire;
    logic        out_fire;

    jzjpcc_imm_range_check u_range (
        .opcode_i (opcode),
        .imm_i    (immediate),
        .fmt_o    (fmt_c),
        .err_o    (rerr_c)
    );

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_load;
    assign in_ready = !reset && (!s1_valid_q || s1_adv);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (s1_adv) s1_valid_d = 1'b0;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_d.opcode = opcode;
            s1_d.rd     = rd;
            s1_d.rs1    = rs1;
            s1_d.rs2    = rs2;
            s1_d.funct3 = funct3;
            s1_d.funct7 = funct7;
            s1_d.imm    = immediate;
            s1_d.fmt    = fmt_c;
            s1_d.err    = rerr_c;
        end
    end

    // Out-of-range immediates still pack their truncated low bits
    always_comb begin
        op7 = {s1_q.opcode, 2'b11};
        imm = s1_q.imm;
        unique case (s1_q.fmt)
            FMT_R: pack_c = {s1_q.funct7, s1_q.rs2, s1_q.rs1,
                             s1_q.funct3, s1_q.rd, op7};
            FMT_I: pack_c = {imm[11:0], s1_q.rs1,
                             s1_q.funct3, s1_q.rd, op7};
            FMT_S: pack_c = {imm[11:5], s1_q.rs2, s1_q.rs1,
                             s1_q.funct3, imm[4:0], op7};
            FMT_B: pack_c = {imm[12], imm[10:5], s1_q.rs2, s1_q.rs1,
                             s1_q.funct3, imm[4:1], imm[11], op7};
            FMT_U: pack_c = {imm[31:12], s1_q.rd, op7};
            FMT_J: pack_c = {imm[20], imm[10:1], imm[11],
                             imm[19:12], s1_q.rd, op7};
            default: pack_c = {25'b0, op7};
        endcase
    end

    always_comb begin
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        word_d     = s1_adv ? pack_c : word_q;
        err_d      = s1_adv ? s1_q.err : err_q;
        cnt_d      = cnt_q;
        if (out_fire && err_q && (cnt_q != '1))
            cnt_d = cnt_q + ERROR_COUNT_WIDTH'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            word_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            word_q     <= word_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign instruction = word_q;
    assign imm_error   = err_q;
    assign error_count = cnt_q;

endmodule

// File: tb/tb_jzjpcc_instruction_encoder.sv
// Directed bench for the instruction encoder with an in-order output queue.
module tb_jzjpcc_instruction_encoder;

    localparam int ECW = 4;

    logic           clock;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [4:0]     opcode, rd, rs1, rs2;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [31:0]    immediate;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    instruction;
    logic           imm_error;
    logic [ECW-1:0] error_count;

    jzjpcc_instruction_encoder #(.ERROR_COUNT_WIDTH(ECW)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct3      (funct3),
        .funct7      (funct7),
        .immediate   (immediate),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instruction (instruction),
        .imm_error   (imm_error),
        .error_count (error_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_out   = 0;
    int exp_cnt = 0;

    logic [31:0] q_w[$];
    bit          q_e[$];
    int          q_t[$];
    int          q_lat[$];
    string       q_tag[$];

    logic [31:0] cur_w;
    bit          cur_e;
    int          cur_lat;
    string       cur_tag;
    bit          last_fire;
    bit          last_stall;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // One clock: evaluate both handshakes before the edge, then advance.
    task automatic tick();
        logic [31:0] w;
        bit          e;
        int          t;
        int          lat;
        string       tg;
        #1;
        last_fire  = !reset && in_valid && in_ready;
        last_stall = !reset && in_valid && !in_ready;
        if (last_fire) begin
            q_w.push_back(cur_w);
            q_e.push_back(cur_e);
            q_t.push_back(cyc);
            q_lat.push_back(cur_lat);
            q_tag.push_back(cur_tag);
        end
        if (!reset && out_valid === 1'b1 && out_ready) begin
            if (q_w.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                w   = q_w.pop_front();
                e   = q_e.pop_front();
                t   = q_t.pop_front();
                lat = q_lat.pop_front();
                tg  = q_tag.pop_front();
                check({tg, "_word"}, instruction, w);
                check({tg, "_err"}, {31'b0, imm_error}, {31'b0, e});
                if (lat != 0)
                    check({tg, "_latency"}, cyc - t, lat);
                if (e && exp_cnt != (1 << ECW) - 1) exp_cnt++;
                n_out++;
            end
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic send(input string tag, input logic [4:0] op,
                        input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] w, input bit e, input int lat);
        bit done;
        opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; immediate = imm;
        cur_w = w; cur_e = e; cur_lat = lat; cur_tag = tag;
        in_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            done = last_fire;
        end
        if (!done) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        in_valid  = 1'b0;
        immediate = 32'hDEAD_BEEF;
        opcode    = 5'b11111;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && q_w.size() != 0; i++) tick();
        check({tag, "_drained"}, q_w.size(), 0);
    endtask

    int  k;
    int  idx;
    int  base;
    bit  saw_stall;
    logic [31:0] bp_w[5];

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        funct3 = '0; funct7 = '0; immediate = '0;
        cur_w = '0; cur_e = 1'b0; cur_lat = 0; cur_tag = "";
        repeat (3) @(negedge clock);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_instruction", instruction, 0);
        check("rst_imm_error", {31'b0, imm_error}, 0);
        check("rst_error_count", {28'b0, error_count}, 0);
        check("rst_in_ready", {31'b0, in_ready}, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 1);

        send("addi", 5'b00100, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0,
             32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0, 2);
        drain("addi");
        send("sw", 5'b01000, 5'd31, 5'd3, 5'd5, 3'd2, 7'd0,
             32'd8, 32'h0051_A423, 1'b0, 2);
        send("lui", 5'b01101, 5'd5, 5'd7, 5'd9, 3'd3, 7'd0,
             32'h1234_5000, 32'h1234_52B7, 1'b0, 2);
        send("jal", 5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
             32'h0000_0800, 32'h0010_00EF, 1'b0, 2);
        send("sub", 5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20,
             32'hDEAD_BEEF, 32'h4020_81B3, 1'b0, 2);
        send("auipc", 5'b00101, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0,
             32'hFFFF_F000, 32'hFFFF_F117, 1'b0, 2);
        send("jalr", 5'b11001, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0,
             32'hFFFF_FFFC, 32'hFFC0_80E7, 1'b0, 2);
        drain("basic");
        check("err_cnt_clean", {28'b0, error_count}, 0);

        send("beq_odd", 5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
             32'd3, 32'h0000_0163, 1'b1, 0);
        send("beq_far", 5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
             32'd4096, 32'h8000_0063, 1'b1, 0);
        drain("branch");
        check("err_cnt_branch", {28'b0, error_count}, 2);

        send("bad_op", 5'b11111, 5'd3, 5'd4, 5'd5, 3'd7, 7'h7F,
             32'd0, 32'h0000_007F, 1'b1, 0);
        send("i_max", 5'b00100, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
             32'd2047, 32'h7FF0_0013, 1'b0, 0);
        send("i_over", 5'b00100, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
             32'd2048, 32'h8000_0013, 1'b1, 0);
        send("i_min", 5'b00100, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
             32'hFFFF_F800, 32'h8000_0013, 1'b0, 0);
        send("s_under", 5'b01000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
             32'hFFFF_F7FF, 32'h7E00_0FA3, 1'b1, 0);
        send("b_max", 5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
             32'd4094, 32'h7E00_0FE3, 1'b0, 0);
        send("j_min", 5'b11011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
             32'hFFF0_0000, 32'h8000_006F, 1'b0, 0);
        send("j_over", 5'b11011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
             32'h0010_0000, 32'h8000_006F, 1'b1, 0);
        send("u_low", 5'b01101, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
             32'h1234_5001, 32'h1234_5037, 1'b1, 0);
        drain("bounds");
        check("err_cnt_bounds", {28'b0, error_count}, exp_cnt);

        // Backpressure: out_ready low on stream cycles 2..5
        bp_w[0] = 32'h0010_0093; bp_w[1] = 32'h0020_0113;
        bp_w[2] = 32'h0030_0193; bp_w[3] = 32'h0040_0213;
        bp_w[4] = 32'h0050_0293;
        idx = 0; k = 0; saw_stall = 1'b0; base = n_out;
        while ((idx < 5 || k <= 5) && k < 40) begin
            out_ready = !(k >= 2 && k <= 5);
            if (idx < 5) begin
                opcode = 5'b00100; rd = 5'(idx + 1); rs1 = '0;
                rs2 = '0; funct3 = '0; funct7 = '0;
                immediate = 32'(idx + 1);
                cur_w = bp_w[idx]; cur_e = 1'b0; cur_lat = 0;
                cur_tag = "bp";
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (last_stall) saw_stall = 1'b1;
            if (last_fire) idx++;
            k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_all_sent", idx, 5);
        drain("bp");
        check("bp_in_ready_dropped", {31'b0, saw_stall}, 1);
        check("bp_out_count", n_out - base, 5);

        // Saturation: 16 more errors on a 4-bit counter
        for (int i = 0; i < 16; i++)
            send("sat", 5'b11111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
                 32'd0, 32'h0000_007F, 1'b1, 0);
        drain("sat");
        check("err_cnt_saturated", {28'b0, error_count}, 15);
        check("err_cnt_model", {28'b0, error_count}, exp_cnt);

        // Reset with two entries in flight
        out_ready = 1'b0;
        send("flight0", 5'b11111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
             32'd0, 32'h0000_007F, 1'b1, 0);
        send("flight1", 5'b00100, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0,
             32'd7, 32'h0070_0493, 1'b0, 0);
        check("flight_out_valid", {31'b0, out_valid}, 1);
        reset = 1'b1;
        tick();
        check("midrst_out_valid", {31'b0, out_valid}, 0);
        check("midrst_error_count", {28'b0, error_count}, 0);
        check("midrst_in_ready", {31'b0, in_ready}, 0);
        q_w.delete(); q_e.delete(); q_t.delete();
        q_lat.delete(); q_tag.delete();
        exp_cnt = 0;
        reset = 1'b0;
        out_ready = 1'b1;
        base = n_out;
        #1;
        check("midrst_in_ready_after", {31'b0, in_ready}, 1);
        repeat (6) tick();
        check("midrst_no_output", n_out - base, 0);
        check("midrst_error_count_after", {28'b0, error_count}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
